// File: rtl/fp_round_arbiter_pkg.sv
// Shared fixed-point definitions: rounding mode encodings
// and default Q(WI.WF) operand widths.
package fp_round_arbiter_pkg;

    localparam int FP_WI = 2;
    localparam int FP_WF = 14;

    localparam logic [1:0] MODE_TRUNC     = 2'b00;
    localparam logic [1:0] MODE_HALF_UP   = 2'b01;
    localparam logic [1:0] MODE_HALF_EVEN = 2'b10;

endpackage

// File: rtl/fp_round.sv
// Combinational rounding of a Q(WI.WF) operand to an integer value.
// Rounds on magnitude, then restores the sign; wraps with no saturation.
module fp_round
    import fp_round_arbiter_pkg::*;
#(
    parameter int WI     = FP_WI,
    parameter int WF     = FP_WF,
    parameter bit SIGNED = 1'b1
) (
    input  logic [WI+WF-1:0] i_data,
    input  logic [1:0]       i_mode,
    output logic [WI+WF-1:0] o_data,
    output logic             o_ovf
);

    localparam int W = WI + WF;

    localparam logic [WF-1:0] HALF = {1'b1, {(WF-1){1'b0}}};
    localparam logic [W-1:0]  ONE  = {{(WI-1){1'b0}}, 1'b1, {WF{1'b0}}};
    localparam logic [W-1:0]  LSB  = {{(W-1){1'b0}}, 1'b1};

    logic          w_neg;
    logic [W-1:0]  w_mag;
    logic [WF-1:0] w_frac;
    logic [W-1:0]  w_trunc;
    logic          w_up;
    logic [W-1:0]  w_rmag;

    // Magnitude split into integer and fraction, rounded, then re-signed
    always_comb begin
        w_neg   = SIGNED && i_data[W-1];
        w_mag   = w_neg ? (~i_data + LSB) : i_data;
        w_frac  = w_mag[WF-1:0];
        w_trunc = {w_mag[W-1:WF], {WF{1'b0}}};
        w_up    = 1'b0;
        unique case (i_mode)
            MODE_HALF_UP:   w_up = (w_frac >= HALF);
            MODE_HALF_EVEN: w_up = (w_frac > HALF) ||
                                   ((w_frac == HALF) && w_mag[WF]);
            default:        w_up = 1'b0;
        endcase
        w_rmag = w_trunc + (w_up ? ONE : '0);
        o_data = w_neg ? (~w_rmag + LSB) : w_rmag;
        if (SIGNED) begin
            o_ovf = (!i_data[W-1] && o_data[W-1]) ||
                    (i_data[W-1] && !o_data[W-1] && (o_data != '0));
        end else begin
            o_ovf = w_up && (w_rmag < w_trunc);
        end
    end

endmodule

// File: rtl/fp_round_arbiter.sv
// Round-robin arbiter feeding one shared rounding unit,
// with a single-entry registered output stage.
module fp_round_arbiter
    import fp_round_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int WI = FP_WI,
    parameter int WF = FP_WF,
    parameter int W  = WI + WF,
    parameter int IW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N*W-1:0] req_data,
    input  logic [2*N-1:0] req_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic [IW-1:0]  out_id,
    output logic           out_ovf
);

    logic [IW-1:0] r_ptr;
    logic          r_valid;
    logic [W-1:0]  r_data;
    logic [IW-1:0] r_id;
    logic          r_ovf;

    logic          w_slot_free;
    logic          w_any;
    logic [IW-1:0] w_pick;
    logic [IW-1:0] w_next_ptr;
    logic          w_grant;
    logic [W-1:0]  w_op;
    logic [1:0]    w_mode;
    logic [W-1:0]  w_res;
    logic          w_res_ovf;
    int            v_idx;

    assign w_slot_free = !r_valid || out_ready;
    assign w_grant     = !rst && w_slot_free && w_any;

    // Round-robin search: first valid index starting at the pointer
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        v_idx  = 0;
        for (int k = 0; k < N; k++) begin
            v_idx = (int'(r_ptr) + k) % N;
            if (!w_any && req_valid[v_idx]) begin
                w_any  = 1'b1;
                w_pick = IW'(v_idx);
            end
        end
    end

    // One-hot accept, suppressed in reset or when the slot is busy
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N; i++) begin
            req_ready[i] = w_grant && (w_pick == IW'(i));
        end
    end

    assign w_next_ptr = (w_pick == IW'(N - 1)) ? '0 : w_pick + 1'b1;
    assign w_op       = req_data[w_pick*W +: W];
    assign w_mode     = req_mode[w_pick*2 +: 2];

    fp_round #(
        .WI     (WI),
        .WF     (WF),
        .SIGNED (1'b1)
    ) u_round (
        .i_data (w_op),
        .i_mode (w_mode),
        .o_data (w_res),
        .o_ovf  (w_res_ovf)
    );

    // Output register: load on grant, drain when free and idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_id    <= '0;
            r_ovf   <= 1'b0;
            r_ptr   <= '0;
        end else if (w_slot_free) begin
            if (w_any) begin
                r_valid <= 1'b1;
                r_data  <= w_res;
                r_id    <= w_pick;
                r_ovf   <= w_res_ovf;
                r_ptr   <= w_next_ptr;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_id    = r_id;
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_fp_round_arbiter.sv
// Bench for fp_round_arbiter: vector table, corner sequences
// and a scoreboard on every retired result.
module tb_fp_round_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_data;
    logic [2*N-1:0] req_mode;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_id;
    logic           out_ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] d;
        logic [1:0]   id;
        logic         ovf;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        int           req;
        logic [W-1:0] din;
        logic [1:0]   mode;
        logic [W-1:0] dout;
        logic         ovf;
    } vec_t;

    vec_t vt[11];

    always #5 clk = ~clk;

    fp_round_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_mode  (req_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ovf   (out_ovf)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Reference rounding in integer arithmetic: {ovf, data}
    function automatic logic [W:0] model(input logic [W-1:0] d,
                                         input logic [1:0] m);
        int v, mag, q, f, up, r, res;
        logic [W-1:0] o;
        logic ov;
        v   = int'($signed(d));
        mag = (v < 0) ? -v : v;
        q   = mag / 16384;
        f   = mag % 16384;
        up  = 0;
        if (m == 2'b01 && f >= 8192) up = 1;
        if (m == 2'b10 && (f > 8192 || (f == 8192 && (q % 2) == 1)))
            up = 1;
        r   = (q + up) * 16384;
        res = (v < 0) ? -r : r;
        o   = res[W-1:0];
        ov  = (v >= 0 && o[W-1]) ||
              (v < 0 && int'($signed(o)) > 0);
        return {ov, o};
    endfunction

    // Scoreboard: retire first, then record the new grant
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_data", {16'h0, out_data}, {16'h0, e.d});
                    chk("sb_id", {30'h0, out_id}, {30'h0, e.id});
                    chk("sb_ovf", {31'h0, out_ovf}, {31'h0, e.ovf});
                end
            end
            chk("rdy_subset", {28'h0, req_ready & ~req_valid}, 0);
            chk("rdy_onehot", {31'h0, $onehot0(req_ready)}, 1);
            if (out_valid && !out_ready)
                chk("rdy_stall", {28'h0, req_ready}, 0);
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    logic [W:0] r;
                    exp_t e;
                    r = model(req_data[i*W +: W], req_mode[2*i +: 2]);
                    e.d = r[W-1:0];
                    e.id = 2'(i);
                    e.ovf = r[W];
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [W-1:0] d,
                           input logic [1:0] m);
        req_data[i*W +: W] = d;
        req_mode[2*i +: 2] = m;
    endtask

    initial begin
        logic [W:0] e3;
        logic [N-1:0] oh;
        rst       = 1'b1;
        req_valid = '1;
        req_data  = '0;
        req_mode  = '0;
        out_ready = 1'b1;

        vt[0]  = '{0,  16'h3000, 2'b01, 16'h4000, 1'b0};
        vt[1]  = '{2,  16'h6000, 2'b10, 16'h8000, 1'b1};
        vt[2]  = '{1,  16'hE000, 2'b10, 16'h0000, 1'b0};
        vt[3]  = '{1,  16'hE000, 2'b01, 16'hC000, 1'b0};
        vt[4]  = '{3,  16'hA000, 2'b11, 16'hC000, 1'b0};
        vt[5]  = '{3,  16'hA000, 2'b00, 16'hC000, 1'b0};
        vt[6]  = '{0,  16'h2000, 2'b10, 16'h0000, 1'b0};
        vt[7]  = '{0,  16'h1FFF, 2'b01, 16'h0000, 1'b0};
        vt[8]  = '{2,  16'h7FFF, 2'b01, 16'h8000, 1'b1};
        vt[9]  = '{1,  16'h8000, 2'b01, 16'h8000, 1'b0};
        vt[10] = '{0,  16'h7000, 2'b00, 16'h4000, 1'b0};

        // Reset state with all requesters valid
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", {31'h0, out_valid}, 0);
        chk("rst_data", {16'h0, out_data}, 0);
        chk("rst_id", {30'h0, out_id}, 0);
        chk("rst_ovf", {31'h0, out_ovf}, 0);
        chk("rst_ready", {28'h0, req_ready}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;

        // Vector table, one requester at a time
        for (int t = 0; t < 11; t++) begin
            @(posedge clk); #1;
            set_req(vt[t].req, vt[t].din, vt[t].mode);
            oh = '0;
            oh[vt[t].req] = 1'b1;
            req_valid = oh;
            @(negedge clk);
            chk("vec_grant", {28'h0, req_ready}, {28'h0, oh});
            @(posedge clk); #1;
            req_valid = '0;
            @(negedge clk);
            chk("vec_valid", {31'h0, out_valid}, 1);
            chk("vec_data", {16'h0, out_data}, {16'h0, vt[t].dout});
            chk("vec_id", {30'h0, out_id}, vt[t].req);
            chk("vec_ovf", {31'h0, out_ovf}, {31'h0, vt[t].ovf});
        end

        // Round robin from reset, all valid
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < N; i++)
            set_req(i, 16'h1000 * 16'(i + 1) + 16'h0800, 2'(i % 3));
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_grant", {28'h0, req_ready}, 32'h1 << (k % 4));
            if (k > 0)
                chk("rr_id", {30'h0, out_id}, (k - 1) % 4);
        end

        // Backpressure: requester 3's result held for 5 cycles
        @(posedge clk); #1;
        out_ready = 1'b0;
        e3 = model(req_data[3*W +: W], req_mode[2*3 +: 2]);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", {31'h0, out_valid}, 1);
            chk("bp_id", {30'h0, out_id}, 3);
            chk("bp_data", {16'h0, out_data}, {16'h0, e3[W-1:0]});
            chk("bp_ready", {28'h0, req_ready}, 0);
            if (k < 4) @(posedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", {28'h0, req_ready}, 32'h1);

        // Reset while a result is held
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = 4'b1010;
        @(negedge clk);
        chk("mid_rst_ready", {28'h0, req_ready}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", {31'h0, out_valid}, 0);
        chk("mid_rst_grant", {28'h0, req_ready}, 32'h2);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_id", {30'h0, out_id}, 1);
        chk("mid_rst_hold", {28'h0, req_ready}, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        req_valid = '0;

        // Random traffic checked by the scoreboard
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            req_valid = N'($urandom_range(0, 15));
            req_data  = {$urandom, $urandom};
            req_mode  = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end

        // Drain with a bounded wait
        @(posedge clk); #1;
        req_valid = '0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() != 0; c++)
            @(posedge clk);
        @(negedge clk);
        chk("drain_empty", sb.size(), 0);
        chk("drain_valid", {31'h0, out_valid}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_round_arbiter.md
FP_ROUND_ARBITER -- requirements
Module: fp_round_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters, 2..8.
REQ-002 Parameter WI, default 2: integer bits of the Q(WI.WF) two's-complement operand.
REQ-003 Parameter WF, default 14: fraction bits; W = WI+WF.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  N  per-requester request valid.
REQ-007 req_ready  output  N  one-hot grant/accept; bit i high means requester i's beat is taken this cycle.
REQ-008 req_data  input  N*W  packed operands; requester i at bits [i*W +: W].
REQ-009 req_mode  input  2*N  packed rounding modes; requester i at bits [2i +: 2].
REQ-010 out_valid  output  1  result register holds a valid result.
REQ-011 out_ready  input  1  downstream accepts the result when high with out_valid.
REQ-012 out_data  output  W  rounded result, Q(WI.WF), fraction bits zero.
REQ-013 out_id  output  clog2(N)  index of the requester that produced out_data.
REQ-014 out_ovf  output  1  rounding overflowed the signed WI-bit integer range.

Function
REQ-015 Modes: 00 truncate magnitude toward zero; 01 round half away from zero; 10 round half to even (on magnitude); 11 treated as 00.
REQ-016 Negative operands round on magnitude, then negate; magnitude +1 wraps modulo 2^W with no saturation.
REQ-017 out_ovf = (input >= 0 and result MSB = 1) or (input < 0 and result > 0); for SIGNED operands only.
REQ-018 Output stage is a single register; "slot free" = !out_valid or out_ready.
REQ-019 A grant is issued only when the slot is free and at least one req_valid is high; otherwise req_ready = 0.
REQ-020 Arbitration is round-robin: search starts at pointer ptr, first valid index in order ptr, ptr+1, ..., wrapping at N.
REQ-021 req_ready is combinational from req_valid, ptr and slot free; at most one bit high; never high for a non-valid requester.
REQ-022 On a grant to i: the result, i and the overflow flag load the output register at the next edge; out_valid = 1; ptr <- (i+1) mod N.
REQ-023 Latency: one cycle from accept to out_valid; throughput one result per cycle while out_ready stays high.
REQ-024 Slot free with no grant: out_valid <- 0 at the next edge, and ptr holds.
REQ-025 While out_valid and !out_ready: out_data, out_id, out_ovf hold stable; no grant.
REQ-026 Simultaneous out_ready and a new grant in the same cycle: old result retires and new result loads; no bubble.
REQ-027 Requesters may deassert req_valid without a grant; no state is affected.

Reset
REQ-028 While rst is high at an edge: out_valid = 0, out_data = 0, out_id = 0, out_ovf = 0, ptr = 0.
REQ-029 req_ready = 0 during any cycle in which rst is high.
REQ-030 Reset mid-transfer discards the held result with no partial output; the first grant after reset goes to the lowest valid index.

Structure
REQ-031 Mode encodings (TRUNC=00, HALF_UP=01, HALF_EVEN=10) live in the shared fixed-point package, together with the Q(WI.WF) default widths.
REQ-032 The existing combinational rounding unit fp_round (SIGNED=1) is instantiated once on the muxed granted operand; rounding is not reimplemented.
REQ-033 Round-robin selection is written as one function or always block in this module; no further sub-modules.

Verification
REQ-034 Default parameters, req 0 only, data 0x3000 (0.75), mode 01, out_ready=1 -> next cycle out_data=0x4000, out_id=0, out_ovf=0.
REQ-035 req 2, data 0x6000 (1.5), mode 10 -> out_data=0x8000, out_ovf=1; req 1, data 0xE000 (-0.5), mode 10 -> out_data=0x0000, out_ovf=0; mode 01 -> 0xC000.
REQ-036 All four requesters valid continuously, out_ready=1, from reset -> grants 0,1,2,3,0,... one per cycle; out_id follows one cycle later.
REQ-037 out_ready held low for 5 cycles with all requesters valid -> out_data/out_id stable and req_ready=0 throughout; on release the next grant is ptr's successor with no lost or duplicated result.
REQ-038 rst asserted for one cycle while out_valid=1 and out_ready=0 -> out_valid=0 and ptr=0 after the edge; with req 1 and req 3 valid, the next grant goes to 1.
REQ-039 Mode 11 with data 0xA000 (-1.5) -> out_data=0xC000 (-1.0), identical to mode 00.
